// File: rtl/wb_stream_master.sv
// wb_stream_master
// Bridges an 8-bit valid/ready command stream to Wishbone B4 pipelined
// transactions, one transaction per frame. A status/data response frame is
// returned on an 8-bit valid/ready stream.
//   Command : opcode (0x01 read, 0x02 write), addr lo, addr hi, [write data LSB first]
//   Response: status (0x00 ack, 0x01 err/rty, 0x02 timeout, 0x03 bad opcode),
//             [read data LSB first, successful reads only]
// Optional feature: define WB_STREAM_MASTER_TIMEOUT_EN to build the bus
// watchdog that ends a transaction after TIMEOUT_CYCLES cycles without a
// termination.
module wb_stream_master #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [7:0]               i_cmd_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [7:0]               o_rsp_data,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
  output logic [BUS_WIDTH-1:0]     o_wb_dat,
  output logic [BUS_WIDTH/8-1:0]   o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic                     i_wb_rty,
  input  logic [BUS_WIDTH-1:0]     i_wb_dat
);

  localparam int         BYTES         = BUS_WIDTH / 8;
  localparam logic [7:0] OP_READ       = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] ST_ACK        = 8'h00;
  localparam logic [7:0] ST_ERR        = 8'h01;
  localparam logic [7:0] ST_TIMEOUT    = 8'h02;
  localparam logic [7:0] ST_BADOP      = 8'h03;
  localparam logic [2:0] DATA_LAST     = 3'(BYTES - 1);
  localparam logic [2:0] RSP_DATA_LAST = 3'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RSP
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q;
  logic                     run_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] adr_q;
  logic [BUS_WIDTH-1:0]     wdat_q;
  logic [BUS_WIDTH+7:0]     rsp_q;
  logic                     rsp_has_data_q;
  logic [7:0]               status;
  logic                     cmd_fire, rsp_fire, rsp_last, opcode_ok;
  logic                     term, expire, rsp_enter;

  assign cmd_fire  = i_cmd_valid && o_cmd_ready;
  assign rsp_fire  = o_rsp_valid && i_rsp_ready;
  assign opcode_ok = (i_cmd_data == OP_READ) || (i_cmd_data == OP_WRITE);
  assign rsp_last  = (cnt_q == (rsp_has_data_q ? RSP_DATA_LAST : 3'd0));
  assign rsp_enter = (state_d == S_RSP) && (state_q != S_RSP);

  // A slave termination only counts once the request has been accepted:
  // in WAIT, or in the REQ cycle where the slave is not stalling.
  assign term = ((state_q == S_REQ && !i_wb_stall) || state_q == S_WAIT) &&
                (i_wb_ack || i_wb_err || i_wb_rty);

`ifdef WB_STREAM_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q;

  // Watchdog: counts cycles with cyc high, cleared whenever no transaction is open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      tmo_q <= '0;
    else if (o_wb_cyc) tmo_q <= tmo_q + 16'd1;
    else               tmo_q <= '0;
  end

  // cyc stays high for exactly TIMEOUT_CYCLES cycles before the watchdog fires.
  assign expire = o_wb_cyc && (tmo_q == TMO_LAST);
`else
  // The watchdog limit has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign expire         = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_fire) state_d = opcode_ok ? S_ADDR : S_RSP;
      S_ADDR: if (cmd_fire && cnt_q == 3'd1) state_d = we_q ? S_DATA : S_REQ;
      S_DATA: if (cmd_fire && cnt_q == DATA_LAST) state_d = S_REQ;
      S_REQ: begin
        if (term || expire)   state_d = S_RSP;
        else if (!i_wb_stall) state_d = S_WAIT;
      end
      S_WAIT: if (term || expire) state_d = S_RSP;
      S_RSP:  if (rsp_fire && rsp_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register. cmd_ready is held off until the
  // first edge after reset so that every output reads 0 while in reset.
  // NOTE: cyc/stb come straight from the asynchronously reset state register,
  // so asserting reset drops the bus cycle without waiting for a clock.
  always_comb begin
    o_cmd_ready = run_q && (state_q inside {S_IDLE, S_ADDR, S_DATA});
    o_wb_cyc    = (state_q == S_REQ) || (state_q == S_WAIT);
    o_wb_stb    = (state_q == S_REQ);
    o_wb_sel    = {BYTES{o_wb_cyc}};
    o_rsp_valid = (state_q == S_RSP);
  end

  // Status code for the response being entered; a termination outranks the
  // watchdog, and err/rty outrank ack.
  always_comb begin
    if (state_q == S_IDLE)       status = ST_BADOP;
    else if (term)               status = (i_wb_err || i_wb_rty) ? ST_ERR : ST_ACK;
    else                         status = ST_TIMEOUT;
  end

  // Frame datapath: byte counter, opcode, write data and response shifter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q          <= 1'b0;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      wdat_q         <= '0;
      rsp_q          <= '0;
      rsp_has_data_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (state_d != state_q)       cnt_q <= '0;
      else if (cmd_fire || rsp_fire) cnt_q <= cnt_q + 3'd1;

      if (state_q == S_IDLE && cmd_fire && opcode_ok) we_q <= (i_cmd_data == OP_WRITE);
      if (state_q == S_DATA && cmd_fire) wdat_q[8*cnt_q +: 8] <= i_cmd_data;

      if (rsp_enter) begin
        rsp_has_data_q <= (status == ST_ACK) && !we_q;
        if (status == ST_ACK && !we_q) rsp_q <= {i_wb_dat, status};
        else                           rsp_q <= {{BUS_WIDTH{1'b0}}, status};
      end else if (rsp_fire) begin
        rsp_q <= {8'h00, rsp_q[BUS_WIDTH+7:8]};
      end
    end
  end

  // Address capture: low byte first; bits above ADDRESS_WIDTH are dropped.
  if (ADDRESS_WIDTH > 8) begin : g_adr_wide
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        adr_q <= '0;
      end else if (state_q == S_ADDR && cmd_fire) begin
        if (cnt_q == 3'd0) adr_q[7:0] <= i_cmd_data;
        else               adr_q[ADDRESS_WIDTH-1:8] <= i_cmd_data[ADDRESS_WIDTH-9:0];
      end
    end
  end else begin : g_adr_narrow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                                        adr_q <= '0;
      else if (state_q == S_ADDR && cmd_fire && cnt_q == 3'd0) adr_q <= i_cmd_data[ADDRESS_WIDTH-1:0];
    end
  end

  assign o_wb_adr   = adr_q;
  assign o_wb_we    = we_q;
  assign o_wb_dat   = wdat_q;
  assign o_rsp_data = rsp_q[7:0];

endmodule

// File: tb/tb_wb_stream_master.sv
// Testbench for wb_stream_master: directed vector table, a reset-in-WAIT
// sequence, and randomized frames checked against a frame-level model.
module tb_wb_stream_master;

  localparam int AW  = 8;
  localparam int BW  = 32;
  localparam int NB  = BW / 8;
  localparam int TMO = 8;
`ifdef WB_STREAM_MASTER_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_RTY = 3;
  localparam logic [7:0] OP_READ = 8'h01, OP_WRITE = 8'h02;

  typedef struct {
    logic [7:0]    op;
    logic [15:0]   adr;
    logic [BW-1:0] wdat;
    logic [BW-1:0] rdat;
    int            stall;
    int            lat;
    int            kind;
    int            rdy_pct;
    logic [7:0]    exp_status;
    int            exp_len;
    int            exp_cyc;
    logic [AW-1:0] exp_adr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cmd_valid, o_cmd_ready, o_rsp_valid, i_rsp_ready;
  logic [7:0]    i_cmd_data, o_rsp_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_adr;
  logic [BW-1:0] o_wb_dat, i_wb_dat;
  logic [NB-1:0] o_wb_sel;
  logic          i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stream_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_rty(i_wb_rty), .i_wb_dat(i_wb_dat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [15:0] adr,
                              input logic [BW-1:0] wdat, input logic [BW-1:0] rdat,
                              input int stall, input int lat, input int kind, input int pct,
                              input logic [7:0] st, input int len, input int cyc);
    vec_t v;
    v.op = op; v.adr = adr; v.wdat = wdat; v.rdat = rdat;
    v.stall = stall; v.lat = lat; v.kind = kind; v.rdy_pct = pct;
    v.exp_status = st; v.exp_len = len; v.exp_cyc = cyc; v.exp_adr = adr[AW-1:0];
    return v;
  endfunction

  // Frame-level reference: what the response and bus occupancy must be.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    int   term_at = v.stall + v.lat;
    r.exp_adr = v.adr[AW-1:0];
    if (v.op != OP_READ && v.op != OP_WRITE) begin
      r.exp_status = 8'h03; r.exp_len = 1; r.exp_cyc = 0;
    end else if (TMO_ON && (v.kind == K_NONE || term_at >= TMO)) begin
      r.exp_status = 8'h02; r.exp_len = 1; r.exp_cyc = TMO;
    end else begin
      r.exp_status = (v.kind == K_ACK) ? 8'h00 : 8'h01;
      r.exp_len    = (r.exp_status == 8'h00 && v.op == OP_READ) ? 1 + NB : 1;
      r.exp_cyc    = term_at + 1;
    end
    return r;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_ready"}, o_cmd_ready, 0);
    check({tag, "_rsp_valid"}, o_rsp_valid, 0);
    check({tag, "_rsp_data"},  o_rsp_data, 0);
    check({tag, "_cyc"},       o_wb_cyc, 0);
    check({tag, "_stb"},       o_wb_stb, 0);
    check({tag, "_we"},        o_wb_we, 0);
    check({tag, "_adr"},       o_wb_adr, 0);
    check({tag, "_dat"},       o_wb_dat, 0);
    check({tag, "_sel"},       o_wb_sel, 0);
  endtask

  // Offer one command byte after a random gap; ack noise must be ignored here.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(2)) begin
      i_wb_ack = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    i_wb_ack    = 1'($urandom_range(1));
    i_cmd_valid = 1'b1;
    i_cmd_data  = b;
    @(negedge clk);
    while (!o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_cmd_ready) check("cmd_ready_timeout", o_cmd_ready, 1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    i_wb_ack    = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] exp_bytes[$];
    int term_at = v.stall + v.lat;
    int idx = 0;
    int n = 0;
    send_byte(v.op);
    if (v.op == OP_READ || v.op == OP_WRITE) begin
      send_byte(v.adr[7:0]);
      send_byte(v.adr[15:8]);
      if (v.op == OP_WRITE)
        for (int i = 0; i < NB; i++) send_byte(v.wdat[8*i +: 8]);
    end
    // Bus phase: slave stalls, accepts, then terminates term_at cycles after REQ entry.
    for (int k = 0; k < v.exp_cyc; k++) begin
      i_wb_stall = (k < v.stall);
      i_wb_dat   = v.rdat;
      i_wb_ack   = (k == term_at) && (v.kind == K_ACK);
      i_wb_err   = (k == term_at) && (v.kind == K_ERR);
      i_wb_rty   = (k == term_at) && (v.kind == K_RTY);
      @(negedge clk);
      check("bus_cyc", o_wb_cyc, 1);
      check("bus_stb", o_wb_stb, (k <= v.stall));
      check("bus_adr", o_wb_adr, v.exp_adr);
      check("bus_we", o_wb_we, (v.op == OP_WRITE));
      check("bus_sel", o_wb_sel, {NB{1'b1}});
      check("bus_cmd_ready", o_cmd_ready, 0);
      if (v.op == OP_WRITE) check("bus_dat", o_wb_dat, v.wdat);
      @(posedge clk); #1;
    end
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rty = 1'b0;
    i_wb_dat   = $urandom();
    // Response phase with random back-pressure.
    exp_bytes.push_back(v.exp_status);
    if (v.exp_len > 1)
      for (int i = 0; i < NB; i++) exp_bytes.push_back(v.rdat[8*i +: 8]);
    while (idx < exp_bytes.size() && n < 200) begin
      i_rsp_ready = ($urandom_range(99) < v.rdy_pct);
      i_wb_ack    = 1'($urandom_range(1));
      @(negedge clk);
      check("rsp_valid", o_rsp_valid, 1);
      if (n == 0) begin
        check("rsp_cyc_low", o_wb_cyc, 0);
        check("rsp_sel_low", o_wb_sel, 0);
      end
      if (o_rsp_valid) begin
        check("rsp_byte", o_rsp_data, exp_bytes[idx]);
        if (i_rsp_ready) idx++;
      end
      @(posedge clk); #1;
      n++;
    end
    i_rsp_ready = 1'b0;
    i_wb_ack    = 1'b0;
    if (idx < exp_bytes.size()) check("rsp_timeout", idx, exp_bytes.size());
    @(negedge clk);
    check("rsp_done_valid", o_rsp_valid, 0);
    check("rsp_done_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  // Read left hanging in WAIT, then reset asynchronously mid-cycle.
  task automatic reset_in_wait();
    int hold = TMO_ON ? 3 : 20;
    send_byte(OP_READ);
    send_byte(8'h55);
    send_byte(8'h00);
    for (int k = 0; k <= hold; k++) begin
      i_wb_stall = 1'b0;
      i_wb_dat   = $urandom();
      @(negedge clk);
      check("hang_cyc", o_wb_cyc, 1);
      check("hang_stb", o_wb_stb, (k == 0));
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check_outputs_zero("rst_release");
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    i_cmd_valid = 1'b0; i_cmd_data = '0; i_rsp_ready = 1'b0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rty = 1'b0;
    i_wb_dat = '0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    //           op     adr       wdat          rdat          st lat kind    rdy  status len  cyc
    tbl[0] = mk(8'h02, 16'h0010, 32'hDEADBEEF, 32'h0,        0, 1, K_ACK, 100, 8'h00, 1, 2);
    tbl[1] = mk(8'h01, 16'h0024, 32'h0,        32'h12345678, 3, 0, K_ACK, 100, 8'h00, 5, 4);
    tbl[2] = mk(8'h01, 16'h0030, 32'h0,        32'hCAFEF00D, 0, 1, K_ERR, 100, 8'h01, 1, 2);
    tbl[3] = mk(8'h7F, 16'h0000, 32'h0,        32'h0,        0, 0, K_ACK, 100, 8'h03, 1, 0);
    tbl[4] = mk(8'h02, 16'h1234, 32'h01020304, 32'h0,        1, 0, K_RTY, 100, 8'h01, 1, 2);
    tbl[5] = mk(8'h01, 16'h00FF, 32'h0,        32'hA5A55A5A, 0, 0, K_ACK,  40, 8'h00, 5, 1);
    tbl[6] = mk(8'h01, 16'h0042, 32'h0,        32'h0BADBEEF, 3, 4, K_ACK,  70, 8'h00, 5, 8);
    tbl[7] = TMO_ON ? mk(8'h02, 16'h0066, 32'h11223344, 32'h0, 2, 6, K_ACK, 100, 8'h02, 1, 8)
                    : mk(8'h02, 16'h0066, 32'h11223344, 32'h0, 2, 6, K_ACK, 100, 8'h00, 1, 9);
    tbl[8] = TMO_ON ? mk(8'h01, 16'h0077, 32'h0, 32'h87654321, 0, 20, K_NONE, 100, 8'h02, 1, 8)
                    : mk(8'h01, 16'h0077, 32'h0, 32'h87654321, 0, 20, K_ACK,   60, 8'h00, 5, 21);
    tbl[9] = mk(8'h00, 16'h0000, 32'h0,        32'h0,        0, 0, K_ACK, 100, 8'h03, 1, 0);

    for (int i = 0; i < 10; i++) run_frame(tbl[i]);

    reset_in_wait();
    run_frame(tbl[1]);

    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(9);
      v.op = (r < 4) ? OP_READ : (r < 8) ? OP_WRITE : 8'h00;
      while (r >= 8 && (v.op == OP_READ || v.op == OP_WRITE)) v.op = 8'($urandom());
      v.adr     = 16'($urandom());
      v.wdat    = $urandom();
      v.rdat    = $urandom();
      v.stall   = $urandom_range(4);
      v.lat     = $urandom_range(4);
      v.kind    = TMO_ON ? int'($urandom_range(3)) : int'($urandom_range(3, 1));
      v.rdy_pct = $urandom_range(100, 30);
      run_frame(predict(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
